// File: rtl/cam_capture_rgb444.sv
// OV7670 capture stage: pairs RGB444 camera bytes ("xR GB") into 12-bit
// pixels and writes them linearly into the frame buffer write port.
// Everything runs on the camera pixel clock.
module cam_capture_rgb444 #(
    parameter int AW           = 15,
    parameter int DW           = 12,
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done
);

    // Address IMASIZ is the RAM's black pixel; the counter saturates there.
    localparam logic [AW-1:0] IMASIZ = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        BYTE1,
        BYTE2
    } state_t;

    state_t        state_q, state_d;
    logic          vsync_q;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [3:0]    red_q, red_d;
    logic          regw_q, regw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          frame_start;

    assign frame_start = vsync_q & ~CAM_vsync;

    // Next-state and output decode; vsync always wins over href.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        red_d   = red_q;
        regw_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (frame_start) begin
                    cnt_d   = '0;
                    state_d = BYTE1;
                end
            end
            BYTE1: begin
                if (CAM_vsync) begin
                    done_d  = 1'b1;
                    state_d = WAIT_FRAME;
                end else if (CAM_href) begin
                    red_d   = CAM_px_data[3:0];
                    state_d = BYTE2;
                end
            end
            BYTE2: begin
                if (CAM_vsync) begin
                    done_d  = 1'b1;
                    red_d   = '0;
                    state_d = WAIT_FRAME;
                end else if (CAM_href) begin
                    if (cnt_q < IMASIZ) begin
                        data_d = DW'({red_q, CAM_px_data});
                        addr_d = cnt_q;
                        regw_d = 1'b1;
                        cnt_d  = cnt_q + AW'(1);
                    end
                    state_d = BYTE1;
                end else begin
                    red_d   = '0;
                    state_d = BYTE1;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    // State, sync history and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
            vsync_q <= 1'b0;
            cnt_q   <= '0;
            red_q   <= '0;
            regw_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= CAM_vsync;
            cnt_q   <= cnt_d;
            red_q   <= red_d;
            regw_q  <= regw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign DP_RAM_regW    = regw_q;
    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign frame_done     = done_q;

endmodule
